// File: rtl/ones_run_pattern_gen.sv
// ones_run_pattern_gen
//   Stimulus generator for the ones-string counter. A start request with run
//   length L sweeps every WIDTH-bit word holding exactly one contiguous run of
//   L ones. The run begins at bit 0 and moves up one bit per accepted word.
//   Each word is paired with its expected longest-run length (L) on a
//   valid/ready stream.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      sweep request, sampled only in IDLE
//   run_len    requested run length L, captured with start
//   out_ready  consumer ready
//   out_valid  word_out/exp_len/word_idx valid (EMIT state)
//   word_out   generated word
//   exp_len    expected longest run of ones in word_out
//   word_idx   0-based position of the current word within the sweep
//   busy       high while emitting
//   done       one-cycle pulse after the final word is accepted
//   err        one-cycle pulse for a start with run_len > WIDTH
module ones_run_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] word_out,
  output logic [LEN_W-1:0] exp_len,
  output logic [LEN_W-1:0] word_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  // One output beat: the word, its expected run length and its sweep index.
  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
  } beat_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);

  state_t           state, state_nxt;
  beat_t            beat_q, beat_nxt;
  logic [LEN_W-1:0] last_q, last_nxt;   // index of the final word of the sweep
  logic             err_q, err_nxt;

  // Run mask built one bit wider than the word so L == WIDTH gives all ones
  // instead of wrapping to zero. The top bit is always 0 for legal L.
  logic [WIDTH:0]   mask_x;
  logic             mask_unused;

  assign mask_x      = (ONE_X << run_len) - ONE_X;
  assign mask_unused = mask_x[WIDTH];

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_q;
    last_nxt  = last_q;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (run_len > WIDTH_L) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt     = EMIT;
            beat_nxt.word = mask_x[WIDTH-1:0];
            beat_nxt.len  = run_len;
            beat_nxt.idx  = '0;
            // L = 0 is a single all-zero word; otherwise WIDTH-L+1 words.
            last_nxt      = (run_len == '0) ? '0 : WIDTH_L - run_len;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (beat_q.idx == last_q) begin
            state_nxt = DONE;
          end else begin
            // Position only advances below last_q, so it saturates there.
            beat_nxt.word = beat_q.word << 1;
            beat_nxt.idx  = beat_q.idx + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      beat_q <= '0;
      last_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      beat_q <= beat_nxt;
      last_q <= last_nxt;
      err_q  <= err_nxt;
    end
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign done      = (state == DONE);
  assign err       = err_q;
  assign word_out  = beat_q.word;
  assign exp_len   = beat_q.len;
  assign word_idx  = beat_q.idx;

endmodule

// File: tb/tb_ones_run_pattern_gen.sv
module tb_ones_run_pattern_gen;
  localparam int WIDTH = 8;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] run_len = '0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [WIDTH-1:0] word_out;
  logic [LEN_W-1:0] exp_len;
  logic [LEN_W-1:0] word_idx;
  logic             busy;
  logic             done;
  logic             err;

  ones_run_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .run_len(run_len),
    .out_ready(out_ready), .out_valid(out_valid), .word_out(word_out),
    .exp_len(exp_len), .word_idx(word_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] l;
    logic [3:0] idx;
    logic [7:0] word;
    bit         first;
    bit         last;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] l, input logic [3:0] idx, input logic [7:0] word,
                     input bit first, input bit last);
    vec_t v;
    v.l = l; v.idx = idx; v.word = word; v.first = first; v.last = last;
    tbl.push_back(v);
  endtask

  task automatic chk_beat(input string name, input logic [7:0] w, input logic [3:0] l,
                          input logic [3:0] idx);
    chk({name, ".valid"}, int'(out_valid), 1);
    chk({name, ".busy"}, int'(busy), 1);
    chk({name, ".word"}, int'(word_out), int'(w));
    chk({name, ".len"}, int'(exp_len), int'(l));
    chk({name, ".idx"}, int'(word_idx), int'(idx));
  endtask

  task automatic chk_done(input string name);
    chk({name, ".done"}, int'(done), 1);
    chk({name, ".valid"}, int'(out_valid), 0);
    chk({name, ".busy"}, int'(busy), 0);
    tick();
    chk({name, ".done_clr"}, int'(done), 0);
    chk({name, ".idle_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] l2w[7];
    logic [7:0] l4w[5];

    // Expected sweeps, hand-computed.
    add(4'd1, 4'd0, 8'h01, 1, 0); add(4'd1, 4'd1, 8'h02, 0, 0);
    add(4'd1, 4'd2, 8'h04, 0, 0); add(4'd1, 4'd3, 8'h08, 0, 0);
    add(4'd1, 4'd4, 8'h10, 0, 0); add(4'd1, 4'd5, 8'h20, 0, 0);
    add(4'd1, 4'd6, 8'h40, 0, 0); add(4'd1, 4'd7, 8'h80, 0, 1);
    add(4'd3, 4'd0, 8'h07, 1, 0); add(4'd3, 4'd1, 8'h0E, 0, 0);
    add(4'd3, 4'd2, 8'h1C, 0, 0); add(4'd3, 4'd3, 8'h38, 0, 0);
    add(4'd3, 4'd4, 8'h70, 0, 0); add(4'd3, 4'd5, 8'hE0, 0, 1);
    add(4'd8, 4'd0, 8'hFF, 1, 1);
    add(4'd0, 4'd0, 8'h00, 1, 1);

    l2w = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};
    l4w = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0};

    // Reset state
    tick(); tick();
    chk("rst.valid", int'(out_valid), 0);
    chk("rst.word", int'(word_out), 0);
    chk("rst.len", int'(exp_len), 0);
    chk("rst.idx", int'(word_idx), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(err), 0);
    reset = 1'b1;
    tick();

    // Illegal run length: err pulse only
    start = 1'b1; run_len = 4'd9;
    tick();
    start = 1'b0;
    chk("err.err", int'(err), 1);
    chk("err.valid", int'(out_valid), 0);
    chk("err.busy", int'(busy), 0);
    chk("err.done", int'(done), 0);
    tick();
    chk("err.clr", int'(err), 0);
    chk("err.valid2", int'(out_valid), 0);
    chk("err.done2", int'(done), 0);

    // Table-driven sweeps at full throughput; each new sweep starts in the
    // first IDLE cycle after done.
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].first) begin
        start = 1'b1; run_len = tbl[i].l;
        tick();
        start = 1'b0;
      end
      chk_beat($sformatf("tbl%0d", i), tbl[i].word, tbl[i].l, tbl[i].idx);
      tick();
      if (tbl[i].last) chk_done($sformatf("tbl%0d", i));
    end

    // Backpressure: L=2, stall on 0x06 for 3 cycles
    start = 1'b1; run_len = 4'd2;
    tick();
    start = 1'b0;
    chk_beat("bp0", l2w[0], 4'd2, 4'd0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_beat($sformatf("bp_hold%0d", k), 8'h06, 4'd2, 4'd1);
      tick();
    end
    out_ready = 1'b1;
    chk_beat("bp_rise", 8'h06, 4'd2, 4'd1);
    tick();
    for (int k = 2; k < 7; k++) begin
      chk_beat($sformatf("bp%0d", k), l2w[k], 4'd2, 4'(k));
      tick();
    end
    chk_done("bp");

    // start held high through an L=4 sweep: no restart, start in DONE dropped
    start = 1'b1; run_len = 4'd4;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_beat($sformatf("hold%0d", k), l4w[k], 4'd4, 4'(k));
      tick();
    end
    chk("hold.done", int'(done), 1);
    chk("hold.valid_done", int'(out_valid), 0);
    start = 1'b0;
    tick();
    chk("hold.idle_valid", int'(out_valid), 0);
    tick();
    chk("hold.no_restart", int'(out_valid), 0);

    // Reset mid-sweep while 0x1C is presented
    start = 1'b1; run_len = 4'd3;
    tick();
    start = 1'b0;
    tick(); tick();
    chk_beat("mid", 8'h1C, 4'd3, 4'd2);
    reset = 1'b0;
    tick();
    chk("mid.valid", int'(out_valid), 0);
    chk("mid.word", int'(word_out), 0);
    chk("mid.len", int'(exp_len), 0);
    chk("mid.idx", int'(word_idx), 0);
    chk("mid.busy", int'(busy), 0);
    chk("mid.done", int'(done), 0);
    reset = 1'b1;
    tick();
    chk("mid.done2", int'(done), 0);
    chk("mid.valid2", int'(out_valid), 0);
    start = 1'b1; run_len = 4'd3;
    tick();
    start = 1'b0;
    chk_beat("mid.restart", 8'h07, 4'd3, 4'd0);
    tick();
    chk_beat("mid.restart1", 8'h0E, 4'd3, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
